ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command request / completion bundle for the PS/2 host transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Sends one byte with the clock-inhibit request sequence and checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_CYCLES   = 1000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_ps2_c,
    input  logic         i_ps2_d,
    output logic         o_ps2_c_drive_low,
    output logic         o_ps2_d_drive_low,
    ps2_host_tx_if.slave tx
);
    localparam int INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FLT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int START_AT = (START_CYCLES >= INHIBIT_CYCLES) ? 0 : INHIBIT_CYCLES - START_CYCLES;

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_XFER, S_WAIT_IDLE, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [1:0]        w_pad;
    logic [1:0]        r_meta, r_sync, r_filt;
    logic [FLT_W-1:0]  r_flt_cnt [2];
    logic              r_c_filt_q;
    logic              w_fall_c;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [3:0]        r_bit_cnt, w_bit_next;
    logic [INH_W-1:0]  r_inh_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_d_low, r_ack;
    logic              w_timeout, w_inh_last, w_start_bit;
    logic              w_done, w_err, w_ack;

    // Index 0 is the clock line, index 1 the data line.
    assign w_pad = {i_ps2_d, i_ps2_c};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta       <= 2'b11;
            r_sync       <= 2'b11;
            r_filt       <= 2'b11;
            r_c_filt_q   <= 1'b1;
            r_flt_cnt[0] <= '0;
            r_flt_cnt[1] <= '0;
        end else begin
            r_meta     <= w_pad;
            r_sync     <= r_meta;
            r_c_filt_q <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_flt_cnt[i] <= '0;
                end else if (r_flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                    r_filt[i]    <= r_sync[i];
                    r_flt_cnt[i] <= '0;
                end else begin
                    r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_fall_c    = r_c_filt_q & ~r_filt[0];
    assign w_bit_next  = (r_bit_cnt == 4'd11) ? 4'd11 : r_bit_cnt + 4'd1;
    assign w_inh_last  = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign w_start_bit = (r_inh_cnt >= INH_W'(START_AT));
    assign w_timeout   = ((r_state == S_XFER) || (r_state == S_WAIT_IDLE)) &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_ack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx.tx_valid) w_state_nx = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (w_inh_last) w_state_nx = S_XFER;
            end
            S_XFER: begin
                if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_done     = 1'b1;
                    w_err      = 1'b1;
                end else if (w_fall_c && (w_bit_next == 4'd11)) begin
                    w_state_nx = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_done     = 1'b1;
                    w_err      = 1'b1;
                end else if (r_filt == 2'b11) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_done     = 1'b1;
                w_ack      = r_ack;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_d_low   <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx.tx_valid) begin
                        r_shift   <= tx.tx_data;
                        r_parity  <= ~^tx.tx_data;
                        r_inh_cnt <= '0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + 1'b1;
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_d_low   <= 1'b1;
                end
                S_XFER: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_fall_c) begin
                        r_bit_cnt <= w_bit_next;
                        // Data changes just after each falling edge; the device reads it on the rise.
                        if (w_bit_next <= 4'd8) begin
                            r_d_low <= ~r_shift[0];
                            r_shift <= r_shift >> 1;
                        end else if (w_bit_next == 4'd9) begin
                            r_d_low <= ~r_parity;
                        end else if (w_bit_next == 4'd10) begin
                            r_d_low <= 1'b0;
                        end else begin
                            r_ack <= ~r_filt[1];
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ps2_c_drive_low = (r_state == S_INHIBIT);
    assign o_ps2_d_drive_low = ((r_state == S_INHIBIT) && w_start_bit) ||
                               (((r_state == S_XFER) || (r_state == S_WAIT_IDLE)) && r_d_low && !w_timeout);

    assign tx.tx_ready = (r_state == S_IDLE);
    assign tx.busy     = (r_state != S_IDLE);
    assign tx.done     = w_done;
    assign tx.err      = w_err;
    assign tx.ack_ok   = w_ack;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH   = 400;
    localparam int START = 100;
    localparam int TO    = 3000;
    localparam int HALF  = 25;
    localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2, M_RESET = 3;

    typedef struct packed { logic ack; logic err; } exp_t;

    logic clk, rstn;
    logic pad_c, pad_d, c_low, d_low;
    logic dev_c_low, dev_d_low, rst_req;
    int   dev_mode;
    bit   dev_glitch;
    bit   dev_aborted;
    logic [9:0] rec;
    logic [9:0] exp_frame_q [$];
    exp_t       sb_q [$];
    exp_t       sb_e;
    logic [9:0] fr_e;
    int n_checks = 0, n_fail = 0;
    int c_run = 0, d_run = 0;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (START),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (8)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_ps2_c          (pad_c),
        .i_ps2_d          (pad_d),
        .o_ps2_c_drive_low(c_low),
        .o_ps2_d_drive_low(d_low),
        .tx               (tx_if)
    );

    // Open-drain wired-AND of host and device pulls.
    assign pad_c = ~(c_low | dev_c_low);
    assign pad_d = ~(d_low | dev_d_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: data LSB first, odd parity bit, stop bit 1.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = ((d >> i) & 8'd1) != 0;
        f[8] = ($countones(d) % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Accept capture, completion scoreboard and inhibit run-length checks.
    always @(negedge clk) begin
        if (rstn && tx_if.done) begin
            check("done_has_expectation", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check("ack_ok", tx_if.ack_ok, sb_e.ack);
                check("err", tx_if.err, sb_e.err);
                if (sb_e.err) check("lines_released_on_timeout", {c_low, d_low}, 2'b00);
            end
        end
        if (rstn && tx_if.tx_valid && tx_if.tx_ready) begin
            if (dev_mode != M_RESET) begin
                sb_q.push_back('{ack: (dev_mode == M_ACK), err: (dev_mode == M_SILENT)});
                if (dev_mode != M_SILENT) exp_frame_q.push_back(frame_of(tx_if.tx_data));
            end
        end
        if (c_low) begin
            c_run++;
            if (d_low) d_run++;
        end else if (c_run != 0) begin
            check("inhibit_len", c_run, INH);
            check("start_overlap_len", d_run, START);
            c_run = 0;
            d_run = 0;
        end
    end

    task automatic half_phase();
        repeat (HALF / 2) @(negedge clk);
        if (dev_glitch) begin
            dev_c_low = ~dev_c_low;
            @(negedge clk);
            dev_c_low = ~dev_c_low;
            repeat (HALF - HALF / 2 - 1) @(negedge clk);
        end else begin
            repeat (HALF - HALF / 2) @(negedge clk);
        end
    endtask

    // Device model: waits for the request, clocks 11 bits, samples on rising edges.
    initial begin : device
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        rst_req   = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && c_low) begin
                while (c_low) @(negedge clk);
                if (dev_mode == M_SILENT) continue;
                repeat (30) @(negedge clk);
                check("start_bit", pad_d, 1'b0);
                dev_aborted = 1'b0;
                for (int n = 1; n <= 11; n++) begin
                    dev_c_low = 1'b1;
                    if (dev_mode == M_RESET && n == 5) begin
                        repeat (20) @(negedge clk);
                        rst_req     = 1'b1;
                        dev_c_low   = 1'b0;
                        dev_aborted = 1'b1;
                        break;
                    end
                    half_phase();
                    dev_c_low = 1'b0;
                    if (n <= 10) rec[n-1] = pad_d;
                    if (n == 10 && dev_mode == M_ACK) dev_d_low = 1'b1;
                    if (n == 11) dev_d_low = 1'b0;
                    half_phase();
                end
                if (!dev_aborted) begin
                    check("frame_expected", (exp_frame_q.size() != 0), 1);
                    if (exp_frame_q.size() != 0) begin
                        fr_e = exp_frame_q.pop_front();
                        check("frame_bits", rec, fr_e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        int cnt;
        @(posedge clk); #1;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_if.tx_ready && cnt < TO + INH + 2000);
        check("request_accepted", tx_if.tx_ready, 1'b1);
        @(posedge clk); #1;
        if (!hold) tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (!tx_if.done && cnt < TO + INH + 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("done_within_budget", tx_if.done, 1'b1);
    endtask

    task automatic run_txn(input logic [7:0] d, input int mode, input bit glitch);
        dev_mode   = mode;
        dev_glitch = glitch;
        send(d, 1'b0);
        wait_done();
    endtask

    initial begin : main
        int cyc;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        dev_mode       = M_ACK;
        dev_glitch     = 1'b0;
        rstn           = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_if.tx_ready, 1'b1);
        check("reset_busy", tx_if.busy, 1'b0);
        check("reset_done", {tx_if.done, tx_if.err, tx_if.ack_ok}, 3'b000);
        check("reset_drive_low", {c_low, d_low}, 2'b00);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_txn(8'hED, M_ACK, 1'b0);
        run_txn(8'h07, M_ACK, 1'b0);
        run_txn(8'h00, M_ACK, 1'b0);
        run_txn(8'h55, M_NOACK, 1'b0);

        // Silent device: completion must come exactly TO cycles after clock release.
        dev_mode = M_SILENT;
        send(8'hF4, 1'b0);
        cyc = 0;
        while (!c_low && cyc < 2 * INH) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (c_low && cyc < 2 * INH) begin @(negedge clk); cyc++; end
        cyc = 1;
        while (!tx_if.done && cyc < TO + 100) begin @(negedge clk); cyc++; end
        check("timeout_cycles", cyc, TO);
        @(negedge clk);
        check("ready_after_timeout", tx_if.tx_ready, 1'b1);

        // Reset after the 5th falling edge; bit 4 of 0x0F is 0 so data is held low.
        dev_mode = M_RESET;
        send(8'h0F, 1'b0);
        cyc = 0;
        while (!rst_req && cyc < TO) begin @(negedge clk); cyc++; end
        check("reset_point_reached", rst_req, 1'b1);
        check("d_low_before_reset", d_low, 1'b1);
        #3 rstn = 1'b0;
        #1;
        check("async_release", {c_low, d_low}, 2'b00);
        check("async_ready", tx_if.tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        rstn    = 1'b1;
        rst_req = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_reset", tx_if.tx_ready, 1'b1);
        repeat (60) @(negedge clk);

        // 0xFF held during a busy 0xF4 transfer, with clock glitches.
        dev_mode   = M_ACK;
        dev_glitch = 1'b1;
        send(8'hF4, 1'b0);
        #1;
        tx_if.tx_data  = 8'hFF;
        tx_if.tx_valid = 1'b1;
        wait_done();
        @(negedge clk);
        check("next_accept_one_cycle_after_done", tx_if.tx_ready, 1'b1);
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b0;
        wait_done();

        for (int i = 0; i < 10; i++) begin
            run_txn(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK, 1'($urandom_range(0, 1)));
        end

        repeat (100) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("frames_drained", exp_frame_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
